// File: rtl/dm_access_master_pkg.sv
// Shared definitions for the data-memory access initiator.
//   SIZE_B / SIZE_H / SIZE_W : request size encodings (2'b11 is illegal)
//   dm_state_e               : FSM state encoding S_IDLE/S_RD/S_WR/S_RESP
//   DM_WORDS_DEFAULT         : default memory depth in words
//   is_misaligned()          : alignment check on size and the low address bits
package dm_access_master_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int DM_WORDS_DEFAULT = 3072;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } dm_state_e;

  // The illegal size 2'b11 is folded into the alignment fault so that it
  // raises AdEL/AdES without needing its own exception path.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] low);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = low[0];
      SIZE_W:  bad = (low != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane helper for the data-memory access initiator. Purely combinational.
//   buffer      : word read from memory (or passed straight through on a load)
//   wdata       : store data, meaningful bits in the low lanes
//   size        : SIZE_B / SIZE_H / SIZE_W
//   is_unsigned : zero-extend instead of sign-extend on extraction
//   lane        : addr[1:0] of the access
//   merged      : buffer with the selected lane replaced by wdata (store path)
//   extracted   : selected lane of buffer, extended to 32 bits (load path)
module dm_lane_unit
  import dm_access_master_pkg::*;
(
  input  logic [31:0] buffer,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store merge: memory has no byte enables, so the untouched lanes come
  // from the word read in the RD phase.
  always_comb begin
    merged = buffer;
    case (size)
      SIZE_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  // Load extraction.
  always_comb begin
    case (lane)
      2'd0:    byte_sel = buffer[7:0];
      2'd1:    byte_sel = buffer[15:8];
      2'd2:    byte_sel = buffer[23:16];
      default: byte_sel = buffer[31:24];
    endcase
    half_sel = lane[1] ? buffer[31:16] : buffer[15:0];
    case (size)
      SIZE_B:  extracted = is_unsigned ? {24'h000000, byte_sel}
                                       : {{24{byte_sel[7]}}, byte_sel};
      SIZE_H:  extracted = is_unsigned ? {16'h0000, half_sel}
                                       : {{16{half_sel[15]}}, half_sel};
      default: extracted = buffer;
    endcase
  end

endmodule

// File: rtl/dm_access_master.sv
// Initiator side of the word-wide data-memory interface, between the MEM
// pipeline stage and DM. Performs alignment/range checks, word-only memory
// accesses (sub-word stores become read-modify-write), and returns load data
// or an address exception through a one-cycle response pulse.
//
// Handshake semantics: a request is accepted on a rising edge where
// req_valid and req_ready are both high; req_ready is high only in IDLE. A
// memory access completes on a rising edge where mem_req and mem_ack are both
// high; while mem_ack is low every mem_* output holds its value. resp_valid is
// a single-cycle pulse and resp_rdata/resp_exc_* are zero whenever it is low.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_store/size/unsigned    request kind (size 11 faults as misaligned)
//   req_addr/wdata/pc          byte address, store data, instruction PC
//   resp_valid/rdata           completion pulse and extended load data
//   resp_exc_load/store        AdEL / AdES
//   mem_req/we/addr/wdata/pc   word access to DM (mem_pc feeds the DM trace)
//   mem_rdata/mem_ack          combinational read data, access completion
module dm_access_master
  import dm_access_master_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc_load,
  output logic              resp_exc_store,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_pc,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  dm_state_e state;
  dm_state_e state_next;

  // Fields latched at accept.
  logic              lat_store;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       lat_pc;

  logic [31:0] buffer;
  logic [31:0] lane_word;
  logic [31:0] merged_word;
  logic [31:0] load_word;

  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        exc_load_q, exc_load_d;
  logic        exc_store_q, exc_store_d;

  logic accept;
  logic out_of_range;
  logic req_fault;

  assign accept       = req_valid && (state == S_IDLE);
  assign out_of_range = ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DM_WORDS));
  assign req_fault    = is_misaligned(req_size, req_addr[1:0]) || out_of_range;

  // In RD the load result is registered on the same edge that captures the
  // read word, so extraction looks at mem_rdata directly; in WR the merge
  // works from the captured buffer.
  assign lane_word = (state == S_RD) ? mem_rdata : buffer;

  dm_lane_unit u_lane (
    .buffer      (lane_word),
    .wdata       (lat_wdata),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .lane        (lat_addr[1:0]),
    .merged      (merged_word),
    .extracted   (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    resp_rdata_d = '0;
    exc_load_d   = 1'b0;
    exc_store_d  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault) begin
            state_next  = S_RESP;
            exc_load_d  = ~req_store;
            exc_store_d = req_store;
          end else if (req_store && (req_size == SIZE_W)) begin
            state_next = S_WR;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_next = S_RD;
          end
        end
      end
      S_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (lat_store) begin
            state_next = S_WR;
          end else begin
            state_next   = S_RESP;
            resp_rdata_d = load_word;
          end
        end
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged_word;
        if (mem_ack) state_next = S_RESP;
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_store    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_pc       <= '0;
      buffer       <= '0;
      resp_rdata_q <= '0;
      exc_load_q   <= 1'b0;
      exc_store_q  <= 1'b0;
    end else begin
      if (accept) begin
        lat_store    <= req_store;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        lat_pc       <= req_pc;
      end
      if ((state == S_RD) && mem_ack) buffer <= mem_rdata;
      // The *_d values are non-zero only on the edge entering RESP, so these
      // registers are zero outside the response cycle.
      resp_rdata_q <= resp_rdata_d;
      exc_load_q   <= exc_load_d;
      exc_store_q  <= exc_store_d;
    end
  end

  assign resp_valid     = (state == S_RESP);
  assign resp_rdata     = resp_rdata_q;
  assign resp_exc_load  = exc_load_q;
  assign resp_exc_store = exc_store_q;
  assign mem_addr       = {lat_addr[ADDR_W-1:2], 2'b00};
  assign mem_pc         = lat_pc;

endmodule

// File: tb/tb_dm_access_master.sv
// Self-checking bench for dm_access_master: directed cases for latency,
// lane handling, faults, wait states and reset mid-access, then randomized
// requests against a byte-arithmetic reference memory model.
module tb_dm_access_master;
  import dm_access_master_pkg::*;

  localparam int DMW = 3072;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc_load;
  logic        resp_exc_store;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;
  logic        mem_ack = 1'b1;

  dm_access_master #(.DM_WORDS(DMW), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_pc         (req_pc),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_exc_load  (resp_exc_load),
    .resp_exc_store (resp_exc_store),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_pc         (mem_pc),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exc_q[$];

  logic [31:0] dm_mem  [DMW];  // the memory the DUT talks to
  logic [31:0] ref_mem [DMW];  // reference model memory

  int          write_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  int          rd_wait = 0;
  int          wr_wait = 0;
  int          req_cycles = 0;
  logic [31:0] cur_pc = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- DM model ----------------
  always_comb begin
    if (mem_addr[31:2] < 30'(DMW)) mem_rdata = dm_mem[mem_addr[13:2]];
    else                           mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) begin
      if (mem_addr[31:2] < 30'(DMW)) dm_mem[mem_addr[13:2]] <= mem_wdata;
      write_cnt    <= write_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
  end

  // Ack driver plus stall-stability monitor, evaluated mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (mem_req) begin
      req_cycles++;
      check("mem_pc", mem_pc, cur_pc);
      if (prev_stall) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wdata", mem_wdata, prev_wdata);
        check("hold_we", {31'h0, mem_we}, {31'h0, prev_we});
      end
    end
    if (mem_req && !mem_we && rd_wait > 0) begin
      mem_ack = 1'b0;
      rd_wait--;
    end else if (mem_req && mem_we && wr_wait > 0) begin
      mem_ack = 1'b0;
      wr_wait--;
    end else begin
      mem_ack = 1'b1;
    end
    prev_stall = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_we    = mem_we;
  end

  // ---------------- reference model ----------------
  task automatic ref_exec(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic el,
                          output logic es, output logic dw,
                          output logic [31:0] nw);
    int unsigned idx, nbytes, sh;
    logic [31:0] mask, word;
    idx    = addr / 4;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rd = '0; el = 1'b0; es = 1'b0; dw = 1'b0; nw = '0;
    if (sz == 2'd3 || (addr % nbytes) != 0 || idx >= DMW) begin
      el = !st;
      es = st;
      return;
    end
    word = ref_mem[idx[11:0]];
    sh   = (addr % 4) * 8;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
    if (!st) begin
      rd = (word >> sh) & mask;
      if (!un && nbytes < 4 && rd[8 * nbytes - 1]) rd = rd | ~mask;
    end else begin
      nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[idx[11:0]] = nw;
      dw = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_req(input string tag, input logic st, input logic [1:0] sz,
                         input logic un, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdw, input int wrw);
    logic [31:0] er, ew, got_rd;
    logic el, es, dw;
    logic [1:0] got_exc;
    int lat, n, w0, c0;
    bit got;
    ref_exec(st, sz, un, addr, wd, er, el, es, dw, ew);
    exp_q.push_back(er);
    exc_q.push_back({el, es});
    if (el || es)          lat = 1;
    else if (!st)          lat = 2 + rdw;
    else if (sz == SIZE_W) lat = 2 + wrw;
    else                   lat = 3 + rdw + wrw;

    @(negedge clk);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_idle_resp"}, {31'h0, resp_valid}, 32'h0);
    cur_pc       = $urandom();
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = addr;
    req_wdata    = wd;
    req_pc       = cur_pc;
    w0 = write_cnt;
    c0 = req_cycles;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rd_wait   = rdw;
    wr_wait   = wrw;

    got = 1'b0;
    n   = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1'b1;
    end
    got_rd  = exp_q.pop_front();
    got_exc = exc_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 32'h0, 32'h1);
    end else begin
      check({tag, "_lat"}, n, lat);
      check({tag, "_rdata"}, resp_rdata, got_rd);
      check({tag, "_exc"}, {30'h0, resp_exc_load, resp_exc_store},
            {30'h0, got_exc});
    end
    check({tag, "_writes"}, write_cnt - w0, {31'h0, dw});
    if (el || es) check({tag, "_no_mem"}, req_cycles - c0, 32'h0);
    if (dw) begin
      check({tag, "_wr_addr"}, last_wr_addr, {addr[31:2], 2'b00});
      check({tag, "_wr_data"}, last_wr_data, ew);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n, w0, pulses;
    logic st, un;
    logic [1:0] sz;
    logic [31:0] addr;
    int r, k;

    for (int i = 0; i < DMW; i++) begin
      dm_mem[i]  = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
      ref_mem[i] = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
    end
    dm_mem[4]  = 32'h1122_3344;  ref_mem[4] = 32'h1122_3344;
    dm_mem[8]  = 32'h8000_F0FF;  ref_mem[8] = 32'h8000_F0FF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_exc", {30'h0, resp_exc_load, resp_exc_store}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_pc", mem_pc, 32'h0);

    // Directed cases.
    run_req("sb13", 1'b1, SIZE_B, 1'b0, 32'h13, 32'h0000_00AB, 0, 0);
    run_req("sw10", 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0);
    run_req("lb20", 1'b0, SIZE_B, 1'b0, 32'h20, 32'h0, 0, 0);
    run_req("lbu21", 1'b0, SIZE_B, 1'b1, 32'h21, 32'h0, 0, 0);
    run_req("lh22", 1'b0, SIZE_H, 1'b0, 32'h22, 32'h0, 0, 0);
    run_req("lhu22", 1'b0, SIZE_H, 1'b1, 32'h22, 32'h0, 0, 0);
    run_req("lw20", 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 0, 0);
    run_req("lw22", 1'b0, SIZE_W, 1'b0, 32'h22, 32'h0, 0, 0);
    run_req("sh_oor", 1'b1, SIZE_H, 1'b0, 32'(4 * DMW), 32'h1234, 0, 0);
    run_req("sz11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, 0);
    run_req("sh_wait", 1'b1, SIZE_H, 1'b0, 32'h32, 32'h0000_CAFE, 3, 2);
    run_req("lw_wait", 1'b0, SIZE_W, 1'b0, 32'h30, 32'h0, 2, 0);

    // Reset while a sub-word store is stalled in its write phase.
    @(negedge clk);
    cur_pc       = 32'h0000_4444;
    req_valid    = 1'b1;
    req_store    = 1'b1;
    req_size     = SIZE_H;
    req_addr     = 32'h44;
    req_wdata    = 32'h0000_5A5A;
    req_pc       = cur_pc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rd_wait   = 0;
    wr_wait   = 100;
    n = 0;
    while (!mem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_wr_reached", {31'h0, mem_we}, 32'h1);
    w0        = write_cnt;
    reset     = 1'b1;
    req_valid = 1'b1;  // must be discarded
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_ready", {31'h0, req_ready}, 32'h1);
    check("rstmid_mem_req", {31'h0, mem_req}, 32'h0);
    check("rstmid_mem_we", {31'h0, mem_we}, 32'h0);
    reset   = 1'b0;
    wr_wait = 0;
    pulses  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("rstmid_no_resp", pulses, 32'h0);
    check("rstmid_no_write", write_cnt - w0, 32'h0);
    check("rstmid_mem_intact", dm_mem[17], ref_mem[17]);

    // Randomized requests.
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? SIZE_B : (r < 6) ? SIZE_H : (r < 9) ? SIZE_W : 2'b11;
      k  = $urandom_range(0, 19);
      if (k == 0)      addr = 32'(4 * DMW) + 32'($urandom_range(0, 15));
      else if (k == 1) addr = $urandom();
      else             addr = 32'h100 + 32'($urandom_range(0, 63));
      run_req("rnd", st, sz, un, addr, $urandom(),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Final memory sweep over every word the bench touched.
    for (int i = 0; i < 80; i++) check("mem_sweep", dm_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_access_master.md
Name: dm_access_master

Overview:
- Initiator side of the word-wide data-memory interface. It sits between the MEM pipeline stage and DM.
- Accepts lb/lbu/lh/lhu/lw/sb/sh/sw requests and performs alignment and range checks.
- Drives word-only memory accesses. Sub-word stores become a read-modify-write because DM has no byte enables.
- Returns extended load data or an exception flag through a one-cycle response pulse.

Parameters:
- DM_WORDS, 3072, memory depth in words; word index >= DM_WORDS is out of range.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as an alignment fault
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data in the low bits
- req_pc  in  32  PC of the instruction, for the trace
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_exc_load  out  1  AdEL: misaligned or out-of-range load
- resp_exc_store  out  1  AdES: misaligned or out-of-range store
- mem_req  out  1  memory access active
- mem_we  out  1  word write
- mem_addr  out  32  word-aligned byte address, {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_pc  out  32  latched req_pc, forwarded to the DM trace
- mem_rdata  in  32  combinational read data for mem_addr
- mem_ack  in  1  access completes at this edge; tie to 1 for a zero-wait DM

Behaviour:
- Reset (synchronous): state IDLE and all latched fields 0.
  - Outputs after reset: req_ready=1; resp_*=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_pc=0.
- A request arriving mid-operation while reset is high is discarded, and no memory write is issued after that edge.
- States: IDLE, RD, WR, RESP.
- IDLE: on accept, latch store, size, unsigned, addr, wdata and pc, then run the checks:
  - misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11;
  - out of range: addr[31:2] >= DM_WORDS.
- IDLE next state:
  - check fails -> RESP with exception flag set per direction, and no memory access;
  - load -> RD;
  - word store -> WR;
  - byte or half store -> RD.
- RD: mem_req=1, mem_we=0. When mem_ack=1, capture mem_rdata into a word buffer.
  - Load -> RESP.
  - Sub-word store -> WR.
  - mem_ack=0 -> hold all mem_* outputs stable.
- WR: mem_req=1, mem_we=1, and mem_wdata is:
  - word store: wdata;
  - sub-word store: buffer with the selected lane replaced (byte lane addr[1:0], half lane addr[1]);
  - hold outputs while mem_ack=0; ack -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Load extraction from the buffer:
  - byte = buffer[8*addr[1:0] +: 8], half = buffer[16*addr[1] +: 16];
  - sign-extend unless unsigned; a word load passes the buffer through.
- resp_rdata, resp_exc_* are registered and valid only while resp_valid=1; they are 0 otherwise.
- Latency with mem_ack tied 1, counting the accept edge as T:
  - fault: resp_valid at T+1;
  - load and word store: T+2;
  - sub-word store: T+3.
- Each wait cycle (mem_ack=0) adds exactly one cycle.
- The memory write is committed at the WR edge where mem_ack=1, never earlier.
- Back-to-back requests: the next accept can occur in the IDLE cycle immediately after RESP. There is no overlap.

Decomposition:
- Shared macros header, extending the existing macros include:
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - state encodings S_IDLE/S_RD/S_WR/S_RESP;
  - DM_WORDS default.
- One natural combinational sub-module: dm_lane_unit.
  - Merge: (buffer, wdata, size, addr[1:0]) -> merged store word.
  - Extract: (buffer, size, unsigned, addr[1:0]) -> extended load word.
  - Shared by the WR and RESP paths and unit-testable on its own.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF, ack=1:
  - WR at T+1 with mem_addr=0x10, mem_wdata=0xDEADBEEF, mem_we=1;
  - resp_valid at T+2 with exc=0.
- Memory word 0x10=0x11223344, sb addr=0x13 wdata=0xAB:
  - RD at T+1; WR at T+2 with mem_wdata=0xAB223344;
  - resp_valid at T+3.
- Word 0x20=0x8000F0FF:
  - lb 0x20 -> 0xFFFFFFFF;
  - lbu 0x21 -> 0x000000F0;
  - lh 0x22 -> 0xFFFF8000;
  - lhu 0x22 -> 0x00008000.
- lw addr=0x22 -> resp_exc_load=1 at T+1 and mem_req never asserted. sh addr=4*DM_WORDS -> resp_exc_store=1, no write.
- sh with mem_ack low for 3 cycles in RD and 2 cycles in WR:
  - mem_addr and mem_wdata stay stable throughout;
  - resp_valid at T+8;
  - exactly one write is committed.
- reset asserted during WR with mem_ack=0:
  - after the reset edge: state IDLE, mem_req=0, req_ready=1;
  - no write is committed and no resp_valid pulse occurs.
